sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like port (req/wr/size/addr/wdata/uncached, addr_ok/data_ok) between two SRAM-like requesters: the instruction port (m0) and the data port (m1).
- Sits between the mips core and cpu_axi_interface, so the AXI bridge sees a single in-order requester.
- Keeps an in-order queue of requester IDs for accepted, outstanding transactions. Each returning data_ok/rdata is steered to the correct requester.

Parameters:
- DEPTH, 4, maximum outstanding accepted-but-not-returned transactions (power of two, ≥2).
- RR_MODE, 0, 0 = fixed priority with m1 (data) over m0 (inst); 1 = round-robin.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous assert, active-low.
- mN_req  in  1  request from requester N (N = 0 inst, 1 data); held high until mN_addr_ok.
- mN_wr  in  1  write request.
- mN_size  in  2  transfer size: 0 = byte, 1 = half-word, 2 = word.
- mN_addr  in  32  address.
- mN_wdata  in  32  write data.
- mN_uncached  in  1  uncached attribute.
- mN_rdata  out  32  read data returned to requester N.
- mN_addr_ok  out  1  address accepted for requester N.
- mN_data_ok  out  1  data returned / write completed for requester N.
- s_req  out  1  request to the shared port.
- s_wr  out  1  muxed write flag.
- s_size  out  2  muxed size.
- s_addr  out  32  muxed address.
- s_wdata  out  32  muxed write data.
- s_uncached  out  1  muxed uncached attribute.
- s_rdata  in  32  read data from the shared port.
- s_addr_ok  in  1  shared port accepted the address.
- s_data_ok  in  1  shared port returned data / completed write; returns arrive in acceptance order.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (aresetn low, asynchronous):
  - queue empty; count = 0; lock = 0; rr_last = 0; err = 0.
  - mN_data_ok = 0 and mN_addr_ok = 0 while reset is held.
- Grant selection, evaluated combinationally when lock = 0:
  - RR_MODE 0: m1 wins if m1_req, else m0.
  - RR_MODE 1: when both request, grant the requester that is not rr_last; otherwise grant whichever is requesting.
- Lock, which keeps the shared-port request stable:
  - If s_req is high and s_addr_ok is low at a clock edge, set lock = 1 and hold the grant register at the current grantee.
  - While lock = 1 the grant is frozen, even if the other requester has priority.
  - lock clears on the edge where s_addr_ok is high.
- Shared-port request:
  - s_req = granted mN_req AND (count < DEPTH).
  - Full is judged on the registered count; a same-cycle pop does not free a slot.
  - s_wr, s_size, s_addr, s_wdata, s_uncached mux from the grantee; they are zero when no requester is requesting.
- Address acceptance:
  - mN_addr_ok = s_addr_ok AND s_req AND grant == N, in the same cycle, with no added latency.
  - The non-granted requester sees addr_ok = 0.
- Push: on the edge where s_req AND s_addr_ok, push the grantee ID into the queue and update rr_last to the grantee.
- Return:
  - mN_data_ok = s_data_ok AND (count > 0) AND head == N, in the same cycle.
  - mN_rdata = s_rdata for both requesters (qualified by data_ok).
  - Pop on the edge where s_data_ok AND count > 0.
- Count update on simultaneous push and pop: count is unchanged; read and write pointers both advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Protocol error: s_data_ok while count = 0 sets err = 1.
  - No pop and no data_ok in that cycle.
  - err clears only on reset.
- Drop of request: m_req falling while lock = 1 (before addr_ok) is a requester violation.
  - lock clears on the next edge; nothing is pushed.
- Reset mid-transaction: the queue is flushed. The bridge is reset by the same aresetn, so no stale returns are expected.

Decomposition:
- Package sram_arb_pkg:
  - ID_INST = 1'b0, ID_DATA = 1'b1.
  - Size encodings: SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2.
  - RR_MODE values: ARB_FIXED = 0, ARB_RR = 1.
- Sub-module arb_id_fifo:
  - DEPTH × 1-bit ID queue with push, pop, head, count, full and empty.
  - Asynchronous active-low reset.
  - The top level holds the grant, lock, muxing and error logic.

Test Plan:
- Single request: m0 read of 0xBFC00000 with s_addr_ok the same cycle, then s_data_ok 3 cycles later with s_rdata = 0x3C1DBFC0.
  - Expect m0_addr_ok in cycle 0, m0_data_ok in cycle 3 with that rdata, m1_data_ok = 0.
- Contention, RR_MODE = 0: m0 and m1 request together.
  - Expect m1 granted first (s_addr = m1_addr), then m0.
  - Returns D1 then D0 arrive at m1 then m0 respectively.
- Lock: m0 alone requests with s_addr_ok held low for 4 cycles; m1 raises req in cycle 1.
  - Expect s_addr to stay equal to m0_addr until accepted, then m1 granted.
- Full:
  - With DEPTH = 4, accept 4 requests and return none: a 5th request sees s_req = 0.
  - A pop in the same cycle as the 5th request still gives s_req = 0 in that cycle, and s_req = 1 the next cycle.
- Round-robin, RR_MODE = 1: both requesters request continuously for 6 accepts.
  - Expect grant order 1, 0, 1, 0, 1, 0 (rr_last = 0 after reset gives m1 first).
- Error and reset: s_data_ok with an empty queue gives err = 1 and no mN_data_ok.
  - aresetn asserted mid-burst with 2 outstanding gives err = 0 and count = 0 immediately (asynchronously).

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-requester SRAM-like arbiter:
// requester IDs, transfer sizes, arbitration modes and the command bundle.
package sram_arb_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        uncached;
    } sram_cmd_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order queue of 1-bit requester IDs for outstanding transactions.
// Ports: clk/rst_n, push+push_id, pop, head, count, full, empty.
module arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       push_id,
    input  logic                       pop,
    output logic                       head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= {DEPTH{ID_INST}};
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= push_id;
                wp      <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rp];
    assign full  = (count == DEPTH[AW:0]);
    assign empty = (count == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like port between the inst (m0) and data (m1) requesters.
// Ports: mN_* requester sides, s_* shared side, err sticky protocol error.
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RR_MODE = ARB_FIXED
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_uncached,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_uncached,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_uncached,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          lock;
    logic          gnt_q;
    logic          rr_last;
    logic          gnt;
    logic          sel_req;
    logic          accept;
    logic          pop;
    logic          head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    sram_cmd_t     c0;
    sram_cmd_t     c1;
    sram_cmd_t     cs;

    // A stalled request keeps its grantee so the shared port
    // never sees the command change before addr_ok.
    always_comb begin
        gnt = ID_INST;
        if (lock) begin
            gnt = gnt_q;
        end else if (RR_MODE == ARB_RR && m0_req && m1_req) begin
            gnt = ~rr_last;
        end else if (m1_req) begin
            gnt = ID_DATA;
        end
    end

    assign c0 = '{m0_wr, m0_size, m0_addr, m0_wdata, m0_uncached};
    assign c1 = '{m1_wr, m1_size, m1_addr, m1_wdata, m1_uncached};

    assign sel_req = gnt ? m1_req : m0_req;
    assign cs      = sel_req ? (gnt ? c1 : c0) : '0;

    assign s_wr       = cs.wr;
    assign s_size     = cs.size;
    assign s_addr     = cs.addr;
    assign s_wdata    = cs.wdata;
    assign s_uncached = cs.uncached;

    // Full uses the registered count; a same-cycle pop frees nothing.
    assign s_req  = sel_req && !full && aresetn;
    assign accept = s_req && s_addr_ok;

    assign m0_addr_ok = accept && (gnt == ID_INST);
    assign m1_addr_ok = accept && (gnt == ID_DATA);

    assign pop        = s_data_ok && (count != '0);
    assign m0_data_ok = pop && (head == ID_INST);
    assign m1_data_ok = pop && (head == ID_DATA);
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    // Lock drops on acceptance and also when the grantee withdraws.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lock    <= 1'b0;
            gnt_q   <= ID_INST;
            rr_last <= ID_INST;
            err     <= 1'b0;
        end else begin
            lock  <= s_req && !s_addr_ok;
            gnt_q <= gnt;
            if (accept) begin
                rr_last <= gnt;
            end
            if (s_data_ok && empty) begin
                err <= 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .push    (accept),
        .push_id (gnt),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: lane 0 fixed priority, lane 1 round-robin.
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_sram_like_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n;
    logic [1:0]  m0_req, m0_wr, m0_unc, m1_req, m1_wr, m1_unc;
    logic [1:0]  m0_size [2];
    logic [1:0]  m1_size [2];
    logic [31:0] m0_addr [2];
    logic [31:0] m0_wdata [2];
    logic [31:0] m1_addr [2];
    logic [31:0] m1_wdata [2];
    logic [31:0] m0_rdata [2];
    logic [31:0] m1_rdata [2];
    logic [1:0]  m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [1:0]  s_req, s_wr, s_unc, s_addr_ok, s_data_ok, err;
    logic [1:0]  s_size [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wdata [2];
    logic [31:0] s_rdata [2];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        sram_like_arbiter #(.DEPTH(4), .RR_MODE(g)) dut (
            .aclk        (clk),
            .aresetn     (rst_n[g]),
            .m0_req      (m0_req[g]),
            .m0_wr       (m0_wr[g]),
            .m0_size     (m0_size[g]),
            .m0_addr     (m0_addr[g]),
            .m0_wdata    (m0_wdata[g]),
            .m0_uncached (m0_unc[g]),
            .m0_rdata    (m0_rdata[g]),
            .m0_addr_ok  (m0_addr_ok[g]),
            .m0_data_ok  (m0_data_ok[g]),
            .m1_req      (m1_req[g]),
            .m1_wr       (m1_wr[g]),
            .m1_size     (m1_size[g]),
            .m1_addr     (m1_addr[g]),
            .m1_wdata    (m1_wdata[g]),
            .m1_uncached (m1_unc[g]),
            .m1_rdata    (m1_rdata[g]),
            .m1_addr_ok  (m1_addr_ok[g]),
            .m1_data_ok  (m1_data_ok[g]),
            .s_req       (s_req[g]),
            .s_wr        (s_wr[g]),
            .s_size      (s_size[g]),
            .s_addr      (s_addr[g]),
            .s_wdata     (s_wdata[g]),
            .s_uncached  (s_unc[g]),
            .s_rdata     (s_rdata[g]),
            .s_addr_ok   (s_addr_ok[g]),
            .s_data_ok   (s_data_ok[g]),
            .err         (err[g])
        );

        // Model: queue of owner IDs, held grantee while stalled,
        // last accepted owner, sticky error.
        bit q[$];
        bit stalled, held, last, er;

        function automatic bit who();
            if (stalled) return held;
            if (g == 1 && m0_req[g] && m1_req[g]) return !last;
            return m1_req[g];
        endfunction

        function automatic bit want();
            bit w;
            w = who();
            return (w ? m1_req[g] : m0_req[g]) && (q.size() < 4);
        endfunction

        always @(posedge clk or negedge rst_n[g]) begin
            bit w, r;
            if (!rst_n[g]) begin
                q.delete();
                stalled = 0;
                held = 0;
                last = 0;
                er = 0;
            end else begin
                w = who();
                r = want();
                if (s_data_ok[g] && q.size() == 0) er = 1;
                if (s_data_ok[g] && q.size() > 0) void'(q.pop_front());
                if (r && s_addr_ok[g]) begin
                    q.push_back(w);
                    last = w;
                end
                stalled = r && !s_addr_ok[g];
                held = w;
            end
        end

        always @(negedge clk) begin
            bit w, r, p, h;
            logic [67:0] c0, c1;
            if (rst_n[g]) begin
                w = who();
                r = want();
                p = s_data_ok[g] && q.size() > 0;
                h = (q.size() > 0) ? q[0] : 1'b0;
                c0 = {m0_wr[g], m0_size[g], m0_addr[g], m0_wdata[g], m0_unc[g]};
                c1 = {m1_wr[g], m1_size[g], m1_addr[g], m1_wdata[g], m1_unc[g]};
                chk("s_req", s_req[g], r);
                chk("m0_addr_ok", m0_addr_ok[g], r && s_addr_ok[g] && !w);
                chk("m1_addr_ok", m1_addr_ok[g], r && s_addr_ok[g] && w);
                chk("m0_data_ok", m0_data_ok[g], p && !h);
                chk("m1_data_ok", m1_data_ok[g], p && h);
                chk("err", err[g], er);
                if (p) begin
                    chk("rdata", h ? m1_rdata[g] : m0_rdata[g], s_rdata[g]);
                end
                if (r) begin
                    chk("s_cmd", {s_wr[g], s_size[g], s_addr[g], s_wdata[g], s_unc[g]},
                        w ? c1 : c0);
                end
                if (!m0_req[g] && !m1_req[g]) begin
                    chk("s_cmd_idle", {s_wr[g], s_size[g], s_addr[g], s_wdata[g], s_unc[g]}, 68'd0);
                end
            end
        end
    end

    task automatic clr(input int l);
        m0_req[l] = 0; m0_wr[l] = 0; m0_unc[l] = 0; m0_size[l] = 2'd2;
        m0_addr[l] = 0; m0_wdata[l] = 0;
        m1_req[l] = 0; m1_wr[l] = 0; m1_unc[l] = 0; m1_size[l] = 2'd2;
        m1_addr[l] = 0; m1_wdata[l] = 0;
        s_addr_ok[l] = 0; s_data_ok[l] = 0; s_rdata[l] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int out [2];
    bit a0 [2];
    bit a1 [2];

    initial begin
        rst_n = 2'b00;
        clr(0);
        clr(1);
        m0_req[0] = 1;
        s_addr_ok[0] = 1;
        @(negedge clk);
        chk("rst_addr_ok", m0_addr_ok[0], 0);
        chk("rst_s_req", s_req[0], 0);
        chk("rst_data_ok", m0_data_ok[0], 0);
        chk("rst_err", err[0], 0);
        tick();
        clr(0);
        rst_n = 2'b11;

        // single request, return three cycles later
        tick();
        m0_req[0] = 1; m0_addr[0] = 32'hBFC0_0000; s_addr_ok[0] = 1;
        @(negedge clk);
        chk("t1_addr_ok", m0_addr_ok[0], 1);
        chk("t1_s_addr", s_addr[0], 32'hBFC0_0000);
        tick();
        m0_req[0] = 0; s_addr_ok[0] = 0;
        tick();
        tick();
        s_data_ok[0] = 1; s_rdata[0] = 32'h3C1D_BFC0;
        @(negedge clk);
        chk("t1_data_ok", m0_data_ok[0], 1);
        chk("t1_rdata", m0_rdata[0], 32'h3C1D_BFC0);
        chk("t1_m1_data_ok", m1_data_ok[0], 0);
        tick();
        s_data_ok[0] = 0;

        // contention, fixed priority
        m0_req[0] = 1; m0_addr[0] = 32'h1000;
        m1_req[0] = 1; m1_addr[0] = 32'h2000; m1_wr[0] = 1;
        m1_wdata[0] = 32'hCAFE; s_addr_ok[0] = 1;
        @(negedge clk);
        chk("t2_first", s_addr[0], 32'h2000);
        chk("t2_m1_ok", m1_addr_ok[0], 1);
        chk("t2_m0_wait", m0_addr_ok[0], 0);
        tick();
        m1_req[0] = 0; m1_wr[0] = 0;
        @(negedge clk);
        chk("t2_second", s_addr[0], 32'h1000);
        chk("t2_m0_ok", m0_addr_ok[0], 1);
        tick();
        m0_req[0] = 0; s_addr_ok[0] = 0;
        s_data_ok[0] = 1; s_rdata[0] = 32'hD1;
        @(negedge clk);
        chk("t2_d1_m1", m1_data_ok[0], 1);
        chk("t2_d1_m0", m0_data_ok[0], 0);
        tick();
        s_rdata[0] = 32'hD0;
        @(negedge clk);
        chk("t2_d0_m0", m0_data_ok[0], 1);
        chk("t2_d0_m1", m1_data_ok[0], 0);
        tick();
        s_data_ok[0] = 0;

        // stalled m0 keeps the port while m1 arrives
        m0_req[0] = 1; m0_addr[0] = 32'h3000;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                m1_req[0] = 1; m1_addr[0] = 32'h4000;
            end
            @(negedge clk);
            chk("t3_held", s_addr[0], 32'h3000);
            tick();
        end
        s_addr_ok[0] = 1;
        @(negedge clk);
        chk("t3_m0_ok", m0_addr_ok[0], 1);
        tick();
        m0_req[0] = 0;
        @(negedge clk);
        chk("t3_then_m1", s_addr[0], 32'h4000);
        chk("t3_m1_ok", m1_addr_ok[0], 1);
        tick();
        m1_req[0] = 0; s_addr_ok[0] = 0; s_data_ok[0] = 1;
        @(negedge clk);
        chk("t3_ret_m0", m0_data_ok[0], 1);
        tick();
        @(negedge clk);
        chk("t3_ret_m1", m1_data_ok[0], 1);
        tick();
        s_data_ok[0] = 0;

        // fill the queue
        m0_req[0] = 1; s_addr_ok[0] = 1;
        for (int i = 0; i < 4; i++) begin
            m0_addr[0] = 32'h100 + 32'(4 * i);
            @(negedge clk);
            chk("t4_fill_ok", m0_addr_ok[0], 1);
            tick();
        end
        m0_addr[0] = 32'h200; s_data_ok[0] = 1;
        @(negedge clk);
        chk("t4_full_sreq", s_req[0], 0);
        chk("t4_full_pop", m0_data_ok[0], 1);
        tick();
        s_data_ok[0] = 0;
        @(negedge clk);
        chk("t4_freed_sreq", s_req[0], 1);
        chk("t4_freed_ok", m0_addr_ok[0], 1);
        tick();
        m0_req[0] = 0; s_addr_ok[0] = 0; s_data_ok[0] = 1;
        repeat (4) tick();
        s_data_ok[0] = 0;

        // error on empty return
        s_data_ok[0] = 1;
        @(negedge clk);
        chk("t5_no_m0", m0_data_ok[0], 0);
        chk("t5_no_m1", m1_data_ok[0], 0);
        tick();
        s_data_ok[0] = 0;
        @(negedge clk);
        chk("t5_err", err[0], 1);
        tick();

        // asynchronous reset with two outstanding
        m0_req[0] = 1; s_addr_ok[0] = 1; m0_addr[0] = 32'h500;
        tick();
        m0_addr[0] = 32'h504;
        tick();
        clr(0);
        #2;
        rst_n[0] = 0;
        #1;
        chk("t6_err_clr", err[0], 0);
        chk("t6_count", lane[0].dut.u_fifo.count, 0);
        tick();
        rst_n[0] = 1;

        // round robin lane
        m0_req[1] = 1; m1_req[1] = 1; s_addr_ok[1] = 1;
        for (int i = 0; i < 6; i++) begin
            m0_addr[1] = 32'h600 + 32'(i);
            m1_addr[1] = 32'h700 + 32'(i);
            @(negedge clk);
            chk("t7_rr_m1", m1_addr_ok[1], (i % 2) == 0);
            chk("t7_rr_m0", m0_addr_ok[1], (i % 2) == 1);
            tick();
            s_data_ok[1] = 1;
        end
        m0_req[1] = 0; m1_req[1] = 0; s_addr_ok[1] = 0;
        tick();
        s_data_ok[1] = 0;
        tick();

        // randomized traffic on both lanes
        clr(0);
        clr(1);
        out[0] = 0;
        out[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                a0[l] = m0_addr_ok[l];
                a1[l] = m1_addr_ok[l];
                if (s_req[l] && s_addr_ok[l]) out[l]++;
                if (s_data_ok[l] && out[l] > 0) out[l]--;
            end
            tick();
            for (int l = 0; l < 2; l++) begin
                if (!m0_req[l] || a0[l]) begin
                    m0_req[l] = 1'($urandom_range(0, 1));
                    m0_wr[l] = 1'($urandom);
                    m0_unc[l] = 1'($urandom);
                    m0_size[l] = 2'($urandom_range(0, 2));
                    m0_addr[l] = $urandom;
                    m0_wdata[l] = $urandom;
                end
                if (!m1_req[l] || a1[l]) begin
                    m1_req[l] = 1'($urandom_range(0, 1));
                    m1_wr[l] = 1'($urandom);
                    m1_unc[l] = 1'($urandom);
                    m1_size[l] = 2'($urandom_range(0, 2));
                    m1_addr[l] = $urandom;
                    m1_wdata[l] = $urandom;
                end
                s_addr_ok[l] = ($urandom_range(0, 2) != 0);
                s_data_ok[l] = (out[l] > 0) ? ($urandom_range(0, 1) == 1)
                                            : ($urandom_range(0, 999) == 0);
                s_rdata[l] = $urandom;
            end
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
